debug_inst_encoder: RTL

- Inverse of the instruction decode path. Accepts abstract debug commands (register read, register write, memory load, memory store) and encodes each into a short sequence of legal RV32I instruction words.
- Streams those words into the core's instruction injection port via a valid/ready handshake.
- Sits between the debug transport and the fetch/decode stage. Data is returned through the dscratch CSR or a temp register.

---
 rtl/debug_inst_encoder_if.sv | 32 +++
 rtl/debug_inst_encoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/debug_inst_encoder_if.sv
// Command / instruction-injection / response bundle between the debug
// transport, the encoder and the core's fetch/decode stage.
interface debug_inst_encoder_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_regno;
   logic [31:0] cmd_data;
   logic [1:0]  cmd_size;
   logic        cmd_unsigned;
   logic        flush;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        resp_valid;
   logic        resp_err;

   // Transport/core side: issues commands, consumes instructions and responses.
   modport master (
      output cmd_valid, cmd_op, cmd_regno, cmd_data, cmd_size, cmd_unsigned,
      output flush, inst_ready,
      input  cmd_ready, inst_valid, inst, inst_pc, resp_valid, resp_err
   );

   // Encoder side.
   modport slave (
      input  cmd_valid, cmd_op, cmd_regno, cmd_data, cmd_size, cmd_unsigned,
      input  flush, inst_ready,
      output cmd_ready, inst_valid, inst, inst_pc, resp_valid, resp_err
   );
endinterface

// File: rtl/debug_inst_encoder.sv
// Debug command encoder: turns abstract register/memory debug commands into
// one or two RV32I instruction words and streams them into the core's
// instruction injection port, then pulses a completion response.
module debug_inst_encoder #(
   parameter logic [31:0] PC_BASE       = 32'h0000_0800,
   parameter int          TMP_REG       = 5,
   parameter logic [11:0] DSCRATCH_ADDR = 12'h7B2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   debug_inst_encoder_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EMIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [4:0] TMP = 5'(TMP_REG);

   logic [1:0]  state;
   logic [31:0] q [2];
   logic        two;
   logic        idx;
   logic [31:0] pc;
   logic        err_r;

   // Encoder results for the command currently presented.
   logic [11:0] lo;
   logic [31:0] hi_sum;
   logic [19:0] hi;
   logic [2:0]  f3;
   logic [4:0]  base;
   logic [31:0] mem_word;
   logic [1:0]  enc_n;
   logic        enc_err;
   logic [31:0] enc_q0;
   logic [31:0] enc_q1;

   // Build the instruction sequence for the incoming command.
   always_comb begin
      lo       = bus.cmd_data[11:0];
      hi_sum   = bus.cmd_data + 32'h0000_0800;
      hi       = hi_sum[31:12];
      f3       = (bus.cmd_op == OP_LOAD) ? {bus.cmd_unsigned, bus.cmd_size}
                                         : {1'b0, bus.cmd_size};
      // Small addresses fit the 12-bit offset alone, so x0 is the base.
      base     = (hi == 20'd0) ? 5'd0 : TMP;
      mem_word = (bus.cmd_op == OP_LOAD)
               ? {lo, base, f3, bus.cmd_regno, OPC_LOAD}
               : {lo[11:5], bus.cmd_regno, base, f3, lo[4:0], OPC_STORE};
      enc_n    = 2'd0;
      enc_err  = 1'b0;
      enc_q0   = 32'd0;
      enc_q1   = 32'd0;
      case (bus.cmd_op)
         OP_READ: begin
            enc_n  = 2'd1;
            enc_q0 = {DSCRATCH_ADDR, bus.cmd_regno, 3'b001, 5'd0, OPC_SYSTEM};
         end
         OP_WRITE: begin
            if (bus.cmd_regno != 5'd0) begin
               if (hi == 20'd0) begin
                  enc_n  = 2'd1;
                  enc_q0 = {lo, 5'd0, 3'b000, bus.cmd_regno, OPC_IMM};
               end else if (lo == 12'd0) begin
                  enc_n  = 2'd1;
                  enc_q0 = {hi, bus.cmd_regno, OPC_LUI};
               end else begin
                  enc_n  = 2'd2;
                  enc_q0 = {hi, bus.cmd_regno, OPC_LUI};
                  enc_q1 = {lo, bus.cmd_regno, 3'b000, bus.cmd_regno, OPC_IMM};
               end
            end
         end
         default: begin
            // A store from the temp register cannot survive the LUI that
            // builds the base address, so it is rejected rather than corrupted.
            if (bus.cmd_size == 2'b11 ||
                (bus.cmd_op == OP_LOAD && f3 == 3'b110) ||
                (bus.cmd_op != OP_LOAD && bus.cmd_regno == TMP && hi != 20'd0)) begin
               enc_err = 1'b1;
            end else if (hi == 20'd0) begin
               enc_n  = 2'd1;
               enc_q0 = mem_word;
            end else begin
               enc_n  = 2'd2;
               enc_q0 = {hi, TMP, OPC_LUI};
               enc_q1 = mem_word;
            end
         end
      endcase
   end

   // Command FSM: accept, stream the queued words, then respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         q[0]  <= 32'd0;
         q[1]  <= 32'd0;
         two   <= 1'b0;
         idx   <= 1'b0;
         pc    <= PC_BASE;
         err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  q[0] <= enc_q0;
                  q[1] <= enc_q1;
                  two  <= (enc_n == 2'd2);
                  idx  <= 1'b0;
                  pc   <= PC_BASE;
                  if (enc_err || enc_n == 2'd0) begin
                     state <= RESP;
                     err_r <= enc_err;
                  end else begin
                     state <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (bus.inst_ready) pc <= pc + 32'd4;
               if (bus.flush) begin
                  // A word handshaken this cycle is delivered, but the
                  // command as a whole still reports an abort.
                  state <= RESP;
                  err_r <= 1'b1;
               end else if (bus.inst_ready) begin
                  if (!two || idx) begin
                     state <= RESP;
                     err_r <= 1'b0;
                  end else begin
                     idx <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               err_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = (state == IDLE);
   assign bus.inst_valid = (state == EMIT);
   assign bus.inst       = q[idx];
   assign bus.inst_pc    = pc;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_err   = err_r;

endmodule
